// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared AXI widths, the AR payload struct, arbiter state type and round-robin helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_BURST_FIXED
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR 2'b01
`define AXI_BURST_WRAP 2'b10
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package easyaxi_rd_arb_pkg;

    localparam int AXI_ID_W    = `AXI_ID_W;
    localparam int AXI_ADDR_W  = `AXI_ADDR_W;
    localparam int AXI_LEN_W   = `AXI_LEN_W;
    localparam int AXI_SIZE_W  = `AXI_SIZE_W;
    localparam int AXI_BURST_W = `AXI_BURST_W;
    localparam int AXI_DATA_W  = `AXI_DATA_W;
    localparam int AXI_RESP_W  = `AXI_RESP_W;

    // One master's AR payload, field order matches the concatenation in the top.
    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_t;

    // LOCKED pins the grant while an offered AR waits for slv_arready.
    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_t;

    // Single-step modulo for indices below 2*n, avoids a divider.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/easyaxi_ord_fifo.sv
// Order FIFO holding granted master indices, head names the current R burst owner.
// Latency: push visible at dout/cnt the cycle after; dout is a combinational read of the head.
// Backpressure: caller must not push when full or pop when empty; a pop never frees a same-cycle push.

module easyaxi_ord_fifo
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_cnt == CNT_W'(DEPTH));
    assign empty = (r_cnt == '0);
    assign cnt   = r_cnt;

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks push/pop with push+pop holding steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (pop && !push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/easyaxi_rd_arb.sv
// Round-robin AR arbiter for NUM_MST masters onto one in-order read slave, R routed by an order FIFO.
// Latency: zero; AR and R paths are combinational muxes, FIFO bookkeeping updates on the clock.
// Backpressure: AR held locked on its master until slv_arready; AR blocked when OST_DEPTH bursts are outstanding; R stalls on the owner's rready.

module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int NUM_MST   = 4,
    parameter int OST_DEPTH = 8,
    localparam int IDX_W = $clog2(NUM_MST),
    localparam int CNT_W = $clog2(OST_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MST-1:0]             mst_arvalid,
    output logic [NUM_MST-1:0]             mst_arready,
    input  logic [NUM_MST*AXI_ID_W-1:0]    mst_arid,
    input  logic [NUM_MST*AXI_ADDR_W-1:0]  mst_araddr,
    input  logic [NUM_MST*AXI_LEN_W-1:0]   mst_arlen,
    input  logic [NUM_MST*AXI_SIZE_W-1:0]  mst_arsize,
    input  logic [NUM_MST*AXI_BURST_W-1:0] mst_arburst,
    output logic [NUM_MST-1:0]             mst_rvalid,
    input  logic [NUM_MST-1:0]             mst_rready,
    output logic [AXI_ID_W-1:0]            mst_rid,
    output logic [AXI_DATA_W-1:0]          mst_rdata,
    output logic [AXI_RESP_W-1:0]          mst_rresp,
    output logic                           mst_rlast,
    output logic                           slv_arvalid,
    input  logic                           slv_arready,
    output logic [AXI_ID_W-1:0]            slv_arid,
    output logic [AXI_ADDR_W-1:0]          slv_araddr,
    output logic [AXI_LEN_W-1:0]           slv_arlen,
    output logic [AXI_SIZE_W-1:0]          slv_arsize,
    output logic [AXI_BURST_W-1:0]         slv_arburst,
    input  logic                           slv_rvalid,
    input  logic [AXI_ID_W-1:0]            slv_rid,
    input  logic [AXI_DATA_W-1:0]          slv_rdata,
    input  logic [AXI_RESP_W-1:0]          slv_rresp,
    input  logic                           slv_rlast,
    output logic                           slv_rready,
    output logic [CNT_W-1:0]               ost_cnt
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_grant;
    logic [IDX_W-1:0] w_grant;
    logic [IDX_W-1:0] w_head;
    logic             w_slv_arvalid;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    ar_t              w_ar [NUM_MST];
    ar_t              w_ar_sel;

    // Unpack each master's AR slice into a struct so the mux is a single array select.
    for (genvar k = 0; k < NUM_MST; k++) begin : g_ar_slice
        assign w_ar[k] = {mst_arid[k*AXI_ID_W +: AXI_ID_W],
                          mst_araddr[k*AXI_ADDR_W +: AXI_ADDR_W],
                          mst_arlen[k*AXI_LEN_W +: AXI_LEN_W],
                          mst_arsize[k*AXI_SIZE_W +: AXI_SIZE_W],
                          mst_arburst[k*AXI_BURST_W +: AXI_BURST_W]};
    end

    // First requesting master at or after the rr pointer; descending scan so the nearest wins.
    always_comb begin : p_rr_search
        logic [IDX_W-1:0] idx;
        idx        = '0;
        w_rr_grant = r_rr_ptr;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            idx = IDX_W'(rr_wrap(int'(r_rr_ptr) + i, NUM_MST));
            if (mst_arvalid[idx]) begin
                w_rr_grant = idx;
            end
        end
    end

    assign w_grant     = (r_state == ARB_LOCKED) ? r_lock_idx : w_rr_grant;
    assign w_ar_sel    = w_ar[w_grant];
    assign slv_arid    = w_ar_sel.id;
    assign slv_araddr  = w_ar_sel.addr;
    assign slv_arlen   = w_ar_sel.len;
    assign slv_arsize  = w_ar_sel.size;
    assign slv_arburst = w_ar_sel.burst;
    assign slv_arvalid = w_slv_arvalid;
    assign w_push      = w_slv_arvalid & slv_arready;

    // Lock FSM next state and AR valid; only UNLOCKED looks at FIFO space, so a lock never starts while full.
    always_comb begin
        w_state_nxt   = r_state;
        w_slv_arvalid = 1'b0;
        case (r_state)
            ARB_UNLOCKED: begin
                w_slv_arvalid = ~w_fifo_full & (|mst_arvalid);
                if (w_slv_arvalid && !slv_arready) begin
                    w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                w_slv_arvalid = 1'b1;
                if (slv_arready) begin
                    w_state_nxt = ARB_UNLOCKED;
                end
            end
            default: w_state_nxt = ARB_UNLOCKED;
        endcase
    end

    // Ready goes only to the granted master, and only on an actual handshake.
    always_comb begin
        mst_arready          = '0;
        mst_arready[w_grant] = w_push;
    end

    // State register, lock index capture on entering LOCKED, and rr advance past each winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_UNLOCKED;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ARB_UNLOCKED) && (w_state_nxt == ARB_LOCKED)) begin
                r_lock_idx <= w_grant;
            end
            if (w_push) begin
                r_rr_ptr <= IDX_W'(rr_wrap(int'(w_grant) + 1, NUM_MST));
            end
        end
    end

    // R routing: FIFO head owns the channel; nobody sees rvalid while nothing is outstanding.
    always_comb begin
        mst_rvalid = '0;
        slv_rready = 1'b0;
        if (!w_fifo_empty) begin
            mst_rvalid[w_head] = slv_rvalid;
            slv_rready         = mst_rready[w_head];
        end
    end

    assign w_pop     = slv_rvalid & slv_rready & slv_rlast;
    assign mst_rid   = slv_rid;
    assign mst_rdata = slv_rdata;
    assign mst_rresp = slv_rresp;
    assign mst_rlast = slv_rlast;

    easyaxi_ord_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (OST_DEPTH)
    ) u_ord_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_grant),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .cnt   (ost_cnt)
    );

    a_rvalid_owned: assert property (@(posedge clk) disable iff (rst) !(slv_rvalid && w_fifo_empty));

endmodule
